// File: rtl/packet_flit_injector_if.sv
// Descriptor, payload and router-link signals of packet_flit_injector.
// master = packet source plus router side (drives descriptor, payload, credits); slave = injector.
interface packet_flit_injector_if #(
  parameter int SZw   = 5,
  parameter int EAw   = 4,
  parameter int DAw   = 4,
  parameter int DSTPw = 4,
  parameter int Cw    = 2,
  parameter int V     = 4,
  parameter int FPAYw = 32,
  parameter int Fw    = 2 + V + FPAYw
);
  logic             pck_valid_in;
  logic             pck_ready_out;
  logic [SZw-1:0]   pck_size_in;
  logic [EAw-1:0]   src_e_addr_in;
  logic [DAw-1:0]   dest_e_addr_in;
  logic [DSTPw-1:0] destport_in;
  logic [Cw-1:0]    class_in;
  logic [V-1:0]     vc_num_in;
  logic [FPAYw-1:0] data_in;
  logic             data_valid_in;
  logic             data_ready_out;
  logic [Fw-1:0]    flit_out;
  logic             flit_out_wr;
  logic [V-1:0]     credit_in;
  logic             busy_o;

  modport master (
    output pck_valid_in, pck_size_in, src_e_addr_in, dest_e_addr_in, destport_in,
           class_in, vc_num_in, data_in, data_valid_in, credit_in,
    input  pck_ready_out, data_ready_out, flit_out, flit_out_wr, busy_o
  );

  modport slave (
    input  pck_valid_in, pck_size_in, src_e_addr_in, dest_e_addr_in, destport_in,
           class_in, vc_num_in, data_in, data_valid_in, credit_in,
    output pck_ready_out, data_ready_out, flit_out, flit_out_wr, busy_o
  );
endinterface

// File: rtl/packet_flit_injector.sv
// Packet-to-flit serializer with per-VC credit flow control toward the router local port.
// Define PKT_INJ_STATS_EN to add packet/flit/stall statistics counters.
module packet_flit_injector #(
  parameter int MAX_PCK_SIZE = 16,
  parameter int B            = 4,
  parameter int V            = 4,
  parameter int EAw          = 4,
  parameter int DAw          = 4,
  parameter int DSTPw        = 4,
  parameter int Cw           = 2,
  parameter int FPAYw        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  packet_flit_injector_if.slave bus
`ifdef PKT_INJ_STATS_EN
  ,
  output logic [31:0]           pck_cnt_o,
  output logic [31:0]           flit_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);
  localparam int SZw = $clog2(MAX_PCK_SIZE + 1);
  localparam int CRw = $clog2(B + 1);
  localparam int Fw  = 2 + V + FPAYw;

  localparam logic [1:0] FLG_BODY   = 2'b00;
  localparam logic [1:0] FLG_TAIL   = 2'b01;
  localparam logic [1:0] FLG_HEAD   = 2'b10;
  localparam logic [1:0] FLG_SINGLE = 2'b11;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  state_e           state_q, state_d;
  logic [SZw-1:0]   size_q, size_d, cnt_q, cnt_d;
  logic [EAw-1:0]   src_q, src_d;
  logic [DAw-1:0]   dest_q, dest_d;
  logic [DSTPw-1:0] port_q, port_d;
  logic [Cw-1:0]    class_q, class_d;
  logic [V-1:0]     vc_q, vc_d;
  logic [Fw-1:0]    flit_q, flit_d;
  logic             wr_q, wr_d;
  logic [CRw-1:0]   credit_q [V];

  logic [V-1:0]     credit_nz, dec;
  logic             have_credit, pck_ready, data_ready, last_body;
  logic [FPAYw-1:0] hdr_payload;

  always_comb begin
    for (int v = 0; v < V; v++) credit_nz[v] = (credit_q[v] != '0);
  end

  assign have_credit = |(vc_q & credit_nz);
  assign dec         = wr_d ? vc_q : '0;
  assign last_body   = (cnt_q == size_q - SZw'(1));
  // Header payload from bit 0 up: src, dest, destport, class; weight/be/data stay zero.
  assign hdr_payload = FPAYw'({class_q, port_q, dest_q, src_q});

  assign bus.pck_ready_out  = pck_ready & ~reset;
  assign bus.data_ready_out = data_ready;
  assign bus.flit_out       = flit_q;
  assign bus.flit_out_wr    = wr_q;
  assign bus.busy_o         = (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dest_d     = dest_q;
    port_d     = port_q;
    class_d    = class_q;
    vc_d       = vc_q;
    flit_d     = flit_q;
    wr_d       = 1'b0;
    pck_ready  = 1'b0;
    data_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        pck_ready = 1'b1;
        if (bus.pck_valid_in) begin
          size_d  = bus.pck_size_in;
          src_d   = bus.src_e_addr_in;
          dest_d  = bus.dest_e_addr_in;
          port_d  = bus.destport_in;
          class_d = bus.class_in;
          vc_d    = bus.vc_num_in;
          cnt_d   = '0;
          if (bus.pck_size_in != '0) state_d = HDR;
        end
      end
      HDR: begin
        if (have_credit) begin
          wr_d  = 1'b1;
          cnt_d = SZw'(1);
          if (size_q == SZw'(1)) begin
            flit_d  = {FLG_SINGLE, vc_q, hdr_payload};
            state_d = IDLE;
          end else begin
            flit_d  = {FLG_HEAD, vc_q, hdr_payload};
            state_d = BODY;
          end
        end
      end
      BODY: begin
        data_ready = have_credit;
        if (have_credit && bus.data_valid_in) begin
          wr_d   = 1'b1;
          cnt_d  = cnt_q + SZw'(1);
          flit_d = {last_body ? FLG_TAIL : FLG_BODY, vc_q, bus.data_in};
          if (last_body) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      dest_q  <= '0;
      port_q  <= '0;
      class_q <= '0;
      vc_q    <= '0;
      flit_q  <= '0;
      wr_q    <= 1'b0;
      // NOTE: the credit array is a bank of counters, not storage, so every entry is reset.
      for (int v = 0; v < V; v++) credit_q[v] <= CRw'(B);
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
      port_q  <= port_d;
      class_q <= class_d;
      vc_q    <= vc_d;
      flit_q  <= flit_d;
      wr_q    <= wr_d;
      for (int v = 0; v < V; v++) begin
        unique case ({dec[v], bus.credit_in[v]})
          2'b10:   credit_q[v] <= credit_q[v] - CRw'(1);
          2'b01:   if (credit_q[v] != CRw'(B)) credit_q[v] <= credit_q[v] + CRw'(1);
          default: ;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // A credit returned to a full counter means the router returned more than it was given.
  for (genvar gv = 0; gv < V; gv++) begin : g_credit_chk
    credit_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(bus.credit_in[gv] && !dec[gv] && credit_q[gv] == CRw'(B)));
  end
`endif

`ifdef PKT_INJ_STATS_EN
  logic [31:0] pck_cnt_q, flit_cnt_q, stall_cnt_q;
  logic        blocked;

  assign blocked = (state_q == HDR || state_q == BODY) && !have_credit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pck_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wr_d && flit_d[Fw-2]) pck_cnt_q <= pck_cnt_q + 32'd1;
      if (wr_d)                 flit_cnt_q <= flit_cnt_q + 32'd1;
      if (blocked)              stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign pck_cnt_o   = pck_cnt_q;
  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
